// File: rtl/fpu_unpack_pkg.sv
// Shared FPU types for the unpack stage: rounding mode, one-hot operand class,
// unpacked-operand record, exponent constants and the field classifier.
package fpu_unpack_pkg;

    localparam int FPU_EXP_BIAS    = 127;
    localparam int FPU_EXP_SPECIAL = 255;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } fpu_round_mode_t;

    // One-hot {zero, subnormal, normal, inf, qnan, snan}; CLS_NONE is the reset value
    typedef enum logic [5:0] {
        CLS_NONE   = 6'b000000,
        CLS_ZERO   = 6'b100000,
        CLS_SUB    = 6'b010000,
        CLS_NORMAL = 6'b001000,
        CLS_INF    = 6'b000100,
        CLS_QNAN   = 6'b000010,
        CLS_SNAN   = 6'b000001
    } fpu_class_t;

    typedef struct packed {
        logic            sign;
        logic [9:0]      exponent;
        logic [23:0]     mantissa;
        fpu_class_t      cls;
        fpu_round_mode_t round_mode;
    } fpu_unpacked_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_NORM = 1'b1
    } fpu_unpack_state_t;

    function automatic fpu_class_t fpu_classify(input logic [7:0] e, input logic [22:0] f);
        fpu_class_t c;
        if (e == 8'd0) begin
            c = (f == 23'd0) ? CLS_ZERO : CLS_SUB;
        end else if (e == 8'(FPU_EXP_SPECIAL)) begin
            if (f == 23'd0)  c = CLS_INF;
            else if (f[22])  c = CLS_QNAN;
            else             c = CLS_SNAN;
        end else begin
            c = CLS_NORMAL;
        end
        return c;
    endfunction

endpackage

// File: rtl/fpu_lzc24.sv
// 24-bit combinational leading-zero counter; an all-zero input reports 24.
module fpu_lzc24 (
    input  logic [23:0] data_i,
    output logic [4:0]  lz_o
);

    // Scan upward so the highest set bit is the last one to write the count
    always_comb begin
        lz_o = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (data_i[i]) lz_o = 5'(23 - i);
        end
    end

endmodule

// File: rtl/fpu_unpack.sv
// IEEE-754 single-precision unpacker/normalizer with valid/ready on both sides.
// Subnormals are left-normalized so consumers always see a leading-one mantissa.
// Build option FPU_UNPACK_FAST_NORM_EN: normalize subnormals in a single cycle with
// a leading-zero count and barrel shift; otherwise they are shifted 1 bit per cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | accepting operands; non-subnormals go straight to output
//   ST_NORM | shifting a subnormal left until bit 23 is set (input held off)
module fpu_unpack
    import fpu_unpack_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_data,
    input  fpu_round_mode_t     in_round_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sign,
    output logic signed [9:0]   out_exponent,
    output logic [23:0]         out_mantissa,
    output fpu_class_t          out_class,
    output fpu_round_mode_t     out_round_mode
);

    logic [7:0]    in_exp;
    logic [22:0]   in_frac;
    fpu_class_t    in_cls;
    logic          in_is_sub;
    logic          slot_free;
    logic          accept;
    logic          capture_meta;
    logic          load_direct;
    logic          load_norm;
    logic [9:0]    norm_exp;
    logic [23:0]   norm_mant;
    fpu_unpacked_t direct_res;
    fpu_unpacked_t out_q, out_d;
    logic          out_valid_q, out_valid_d;

    assign in_exp       = in_data[30:23];
    assign in_frac      = in_data[22:0];
    assign in_cls       = fpu_classify(in_exp, in_frac);
    assign in_is_sub    = (in_cls == CLS_SUB);
    assign slot_free    = !out_valid_q || out_ready;
    assign accept       = in_valid && in_ready;
    // Sign and rounding mode of a subnormal are taken at accept; the slot is free then
    assign capture_meta = accept && in_is_sub;

    // Result for zero, normal and special operands: exponent is the raw field
    always_comb begin
        direct_res.sign       = in_data[31];
        direct_res.exponent   = {2'b00, in_exp};
        direct_res.mantissa   = (in_exp == 8'd0) ? 24'd0 : {1'b1, in_frac};
        direct_res.cls        = in_cls;
        direct_res.round_mode = in_round_mode;
    end

`ifdef FPU_UNPACK_FAST_NORM_EN
    logic [4:0] lz;

    fpu_lzc24 u_lzc (
        .data_i ({1'b0, in_frac}),
        .lz_o   (lz)
    );

    assign in_ready    = slot_free;
    assign load_direct = accept && !in_is_sub;
    assign load_norm   = accept && in_is_sub;
    assign norm_mant   = {1'b0, in_frac} << lz;
    assign norm_exp    = 10'd1 - {5'd0, lz};
`else
    fpu_unpack_state_t state_q, state_d;
    logic [23:0]       work_mant_q, work_mant_d;
    logic [9:0]        work_exp_q, work_exp_d;
    logic [23:0]       shift_mant;
    logic              norm_done;

    assign shift_mant = {work_mant_q[22:0], 1'b0};
    assign norm_done  = shift_mant[23];
    assign norm_mant  = shift_mant;
    assign norm_exp   = work_exp_q - 10'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: a subnormal enters NORM, leaves once the final shift can be stored
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && in_is_sub) state_d = ST_NORM;
            ST_NORM: if (norm_done && slot_free) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: handshake, output-load strobes and work-register updates
    always_comb begin
        in_ready    = 1'b0;
        load_direct = 1'b0;
        load_norm   = 1'b0;
        work_mant_d = work_mant_q;
        work_exp_d  = work_exp_q;
        case (state_q)
            ST_IDLE: begin
                in_ready    = slot_free;
                load_direct = accept && !in_is_sub;
                if (accept && in_is_sub) begin
                    work_mant_d = {1'b0, in_frac};
                    work_exp_d  = 10'd1;
                end
            end
            ST_NORM: begin
                if (!norm_done) begin
                    work_mant_d = shift_mant;
                    work_exp_d  = norm_exp;
                end else begin
                    load_norm = slot_free;
                end
            end
            default: ;
        endcase
    end

    // Work registers for the iterative shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_mant_q <= '0;
            work_exp_q  <= '0;
        end else begin
            work_mant_q <= work_mant_d;
            work_exp_q  <= work_exp_d;
        end
    end
`endif

    // Output slot: drain on out_ready, a new load on the same edge takes priority
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (out_ready) out_valid_d = 1'b0;
        if (capture_meta) begin
            out_d.sign       = in_data[31];
            out_d.round_mode = in_round_mode;
        end
        if (load_direct) begin
            out_d       = direct_res;
            out_valid_d = 1'b1;
        end else if (load_norm) begin
            out_d.exponent = norm_exp;
            out_d.mantissa = norm_mant;
            out_d.cls      = CLS_SUB;
            out_valid_d    = 1'b1;
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_sign       = out_q.sign;
    assign out_exponent   = out_q.exponent;
    assign out_mantissa   = out_q.mantissa;
    assign out_class      = out_q.cls;
    assign out_round_mode = out_q.round_mode;

endmodule
